// File: rtl/sync_fifo_4b.sv
// Show-ahead synchronous FIFO with valid/ready on both sides.
// Pointers carry an extra wrap bit so full and empty are told apart without a separate counter.
module sync_fifo_4b #(
    parameter int  WIDTH = 4,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (wp == rp);
    assign full     = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign wr_en    = wr_valid && wr_ready;
    assign rd_en    = rd_valid && rd_ready;
    assign count    = wp - rp;
    assign rd_data  = mem[rp[AW-1:0]];

    // Storage is never reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wp[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en)
                wp <= wp + (AW+1)'(1);
            if (rd_en)
                rp <= rp + (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_sync_fifo_4b.sv
// Randomized and directed bench for sync_fifo_4b against a queue-based reference model.
module tb_sync_fifo_4b;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             reset;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] q[$];

    sync_fifo_4b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of at most DEPTH words.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            int sz;
            logic do_rd, do_wr;
            sz    = q.size();
            do_rd = rd_ready && (sz > 0);
            do_wr = wr_valid && (sz < DEPTH);
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        chk("model_count", int'(count), q.size());
        chk("model_rd_valid", int'(rd_valid), int'(q.size() != 0));
        chk("model_wr_ready", int'(wr_ready), int'(q.size() != DEPTH));
        if (q.size() != 0)
            chk("model_rd_data", int'(rd_data), int'(q[0]));
    end

    task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (rd_valid && n < 4 * DEPTH) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_done", int'(rd_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;

        // Reset held with a pending write: nothing is taken.
        #2;
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        chk("reset_count", int'(count), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_wr_ready", int'(wr_ready), 1);
        wr_valid = 1'b0;
        reset    = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("post_reset_count", int'(count), 0);

        // Fill to full, then hold a 9th write.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, WIDTH'(i), 1'b0);
            chk("fill_count", int'(count), i);
        end
        chk("full_wr_ready", int'(wr_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h9, 1'b0);
            chk("held_count", int'(count), 8);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_data", int'(rd_data), i);
            step(1'b0, '0, 1'b1);
        end
        chk("drained_rd_valid", int'(rd_valid), 0);
        chk("drained_count", int'(count), 0);

        // Wrap-around: write 3 / read 3 for 6 rounds.
        d = '0;
        e = '0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, d, 1'b0);
                d = d + 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                chk("wrap_data", int'(rd_data), int'(e));
                step(1'b0, '0, 1'b1);
                e = e + 1'b1;
            end
        end
        chk("wrap_empty", int'(count), 0);

        // Simultaneous read and write at count=4.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d, 1'b0);
            d = d + 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            chk("simul_data", int'(rd_data), int'(e));
            step(1'b1, d, 1'b1);
            d = d + 1'b1;
            e = e + 1'b1;
            chk("simul_count4", int'(count), 4);
        end

        // Simultaneous at full: read only, then the held write lands.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d, 1'b0);
            d = d + 1'b1;
        end
        chk("full_again", int'(count), 8);
        step(1'b1, 4'hC, 1'b1);
        chk("full_simul_count", int'(count), 7);
        step(1'b1, 4'hC, 1'b1);
        chk("full_simul_next", int'(count), 7);
        drain();

        // Simultaneous at empty: write only, no bypass.
        chk("empty_rd_valid", int'(rd_valid), 0);
        step(1'b1, 4'h3, 1'b1);
        chk("empty_simul_count", int'(count), 1);
        chk("empty_simul_valid", int'(rd_valid), 1);
        chk("empty_simul_data", int'(rd_data), 3);
        drain();

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 5; i++)
            step(1'b1, WIDTH'(i + 6), 1'b0);
        chk("pre_async_count", int'(count), 5);
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_rd_valid", int'(rd_valid), 0);
        @(posedge clk);
        #2;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        reset    = 1'b1;
        step(1'b1, 4'hA, 1'b0);
        chk("after_reset_data", int'(rd_data), 10);
        chk("after_reset_count", int'(count), 1);
        step(1'b0, '0, 1'b1);
        chk("after_reset_empty", int'(rd_valid), 0);

        // Random traffic with varying write/read pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                logic wv, rr;
                case (ph)
                    0: begin wv = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 3) == 0); end
                    1: begin wv = ($urandom_range(0, 3) == 0); rr = ($urandom_range(0, 3) != 0); end
                    default: begin wv = 1'($urandom); rr = 1'($urandom); end
                endcase
                step(wv, WIDTH'($urandom), rr);
            end
        end

        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_4b.md
# sync_fifo_4b

Synchronous first-in first-out buffer that decouples a producer writing 4-bit words from a consumer reading them, both in one clock domain. It adds queueing and backpressure on top of the 4-bit register primitives in the Memory library. Each side uses a valid/ready handshake. The read side presents the oldest stored word as soon as it is available (show-ahead).

## Interface
- WIDTH, 4, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion; deassertion is synchronous to clk externally.
- wr_valid  input  1  producer has a word on wr_data.
- wr_ready  output  1  FIFO can accept a word this cycle (not full).
- wr_data  input  WIDTH  word to write.
- rd_valid  output  1  rd_data holds the oldest stored word (not empty).
- rd_ready  input  1  consumer takes rd_data this cycle.
- rd_data  output  WIDTH  oldest stored word.
- count  output  AW+1  number of stored words, 0..DEPTH.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp and read pointer rp, each AW+1 bits. The extra MSB is a wrap bit.
- Flags:
  - empty = (wp == rp).
  - full = (wp[AW-1:0] == rp[AW-1:0]) and wp[AW] != rp[AW].
  - wr_ready = !full.
  - rd_valid = !empty.
- Write accept (wr_valid & wr_ready): mem[wp[AW-1:0]] <= wr_data, then wp <= wp+1.
- Read accept (rd_valid & rd_ready): rp <= rp+1.
- rd_data = mem[rp[AW-1:0]], combinational from the array. It is a don't-care while rd_valid=0; the bench must not check it then.
- count = wp − rp, modulo 2^(AW+1).
- Pointers wrap naturally modulo 2^(AW+1). No special case at the DEPTH−1 → 0 index rollover.
- Simultaneous read and write accept:
  - Both pointers advance and count is unchanged.
  - When full, wr_ready=0, so only the read is accepted. There is no write-through into a full FIFO.
  - When empty, rd_valid=0, so only the write is accepted. There is no bypass: the word appears one cycle later.
- Write while full (wr_valid=1, wr_ready=0): ignored, no state change. The producer must hold the word.
- Read while empty (rd_ready=1, rd_valid=0): ignored, no state change.
- Reset (reset=0, any time, including mid-burst):
  - Outputs: wp=rp=0, count=0, rd_valid=0, wr_ready=1.
  - Array contents are not cleared; they are unreachable until rewritten.
  - Every in-flight handshake in that cycle is discarded.

## Timing
- All state updates occur on the rising clk edge; reset acts asynchronously.
- Write-to-read latency is 1 cycle: a word accepted at edge N drives rd_valid=1 and rd_data after edge N.
- Read accept at edge N makes the next word visible after edge N, with no bubble. Back-to-back reads sustain 1 word per cycle.
- wr_ready, rd_valid and count are functions of registered pointers only. They have no combinational path from wr_valid or rd_ready.
- Throughput is 1 write plus 1 read per cycle in steady state, when neither full nor empty.

## Test plan
- Reset: hold reset=0 for 2 cycles with wr_valid=1 -> count=0, rd_valid=0, wr_ready=1; no write is taken.
- Fill and drain, rd_ready=0:
  - Write 0x1,0x2,...,0x8 on 8 consecutive cycles -> count steps 1..8; wr_ready=0 after the 8th edge.
  - A 9th write (0x9) held for 3 cycles -> count stays 8.
  - Then rd_ready=1 for 8 cycles -> rd_data reads 0x1..0x8 in order; rd_valid=0 and count=0 after the last edge.
- Wrap-around: repeat write 3 / read 3 cycles for 6 rounds with incrementing data (0x0..0xF, modulo 16) -> every read matches write order; pointers cross index 7→0 and the wrap bit toggles with no loss.
- Simultaneous read and write:
  - With count=4, assert wr_valid=1 and rd_ready=1 for 10 cycles -> count stays 4 and the output order is preserved.
  - At count=8, the same stimulus -> read only; count becomes 7 and the held write is accepted on the next cycle.
  - At count=0, the same stimulus -> write only; count becomes 1 and rd_valid rises 1 cycle later.
- Reset mid-operation: with count=5 during an active write+read, pulse reset=0 asynchronously between edges -> count=0 and rd_valid=0 immediately, without waiting for an edge. After release, writing 0xA gives rd_data=0xA; no stale word appears.
